snoop_bus_arbiter: RTL and testbench

//  N-core snooping bus arbiter/sequencer for the MSI L1 caches; parametrised successor of the 2-core bus.

---
 rtl/snoop_bus_arbiter_if.sv | 48 ++++
 rtl/snoop_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_arbiter_if
// Brief    : Core-side request, snoop broadcast, L2 and response signals of
//            the N-core MSI snooping bus.
// Revision : 1.0 - initial release
// ============================================================================
interface snoop_bus_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int IDX_W = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0]        req;
  logic [2*NUM_CORES-1:0]      req_op;
  logic [ADDR_W*NUM_CORES-1:0] req_addr;
  logic [NUM_CORES-1:0]        gnt;
  logic                        snoop_valid;
  logic [1:0]                  snoop_op;
  logic [ADDR_W-1:0]           snoop_addr;
  logic [IDX_W-1:0]            snoop_src;
  logic [NUM_CORES-1:0]        snoop_hit;
  logic [DATA_W*NUM_CORES-1:0] snoop_data;
  logic                        l2_req;
  logic [ADDR_W-1:0]           l2_addr;
  logic                        l2_ready;
  logic [DATA_W-1:0]           l2_data;
  logic [NUM_CORES-1:0]        resp_valid;
  logic [DATA_W-1:0]           resp_data;
  logic                        resp_shared;
  logic                        busy;

  // Caches and L2 side
  modport master (
    output req, req_op, req_addr, snoop_hit, snoop_data, l2_ready, l2_data,
    input  gnt, snoop_valid, snoop_op, snoop_addr, snoop_src, l2_req, l2_addr,
           resp_valid, resp_data, resp_shared, busy
  );

  // Arbiter side
  modport slave (
    input  req, req_op, req_addr, snoop_hit, snoop_data, l2_ready, l2_data,
    output gnt, snoop_valid, snoop_op, snoop_addr, snoop_src, l2_req, l2_addr,
           resp_valid, resp_data, resp_shared, busy
  );
endinterface
`default_nettype wire

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_arbiter
// Brief    : Round-robin snooping bus sequencer: grant, broadcast, collect
//            peer data or fall back to L2, respond to the granted core.
// Revision : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  snoop_bus_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CORES);

  localparam logic [1:0] OP_BUSRD   = 2'b00;
  localparam logic [1:0] OP_BUSUPGR = 2'b01;
  localparam logic [1:0] OP_NONE    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SNOOP   = 2'd1,
    S_L2_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]     r_win, w_win_nxt;
  logic [1:0]           r_op, w_op_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;

  logic [NUM_CORES-1:0] r_gnt, w_gnt_nxt;
  logic                 r_snoop_valid, w_snoop_valid_nxt;
  logic [1:0]           r_snoop_op, w_snoop_op_nxt;
  logic [ADDR_W-1:0]    r_snoop_addr, w_snoop_addr_nxt;
  logic [IDX_W-1:0]     r_snoop_src, w_snoop_src_nxt;
  logic                 r_l2_req, w_l2_req_nxt;
  logic [ADDR_W-1:0]    r_l2_addr, w_l2_addr_nxt;
  logic [NUM_CORES-1:0] r_resp_valid, w_resp_valid_nxt;
  logic [DATA_W-1:0]    r_resp_data, w_resp_data_nxt;
  logic                 r_resp_shared, w_resp_shared_nxt;
  logic                 r_busy, w_busy_nxt;

  logic [NUM_CORES-1:0] w_elig;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [NUM_CORES-1:0] w_peer_hits;
  logic                 w_peer_any;
  logic [IDX_W-1:0]     w_peer;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_elig
    assign w_elig[g] = bus.req[g] && (bus.req_op[2*g +: 2] != OP_NONE);
  end

  // First eligible core at or after the round-robin pointer, wrapping upward.
  always_comb begin
    int k;
    w_found = 1'b0;
    w_pick  = '0;
    k       = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      k = int'(r_rr_ptr) + i;
      if (k >= NUM_CORES) k = k - NUM_CORES;
      if (!w_found && w_elig[k]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(k);
      end
    end
  end

  // The requester's own hit is meaningless; lowest-index peer supplies data.
  always_comb begin
    w_peer_hits        = bus.snoop_hit;
    w_peer_hits[r_win] = 1'b0;
    w_peer_any         = |w_peer_hits;
    w_peer             = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_peer_hits[i]) w_peer = IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_win_nxt         = r_win;
    w_op_nxt          = r_op;
    w_addr_nxt        = r_addr;
    w_gnt_nxt         = r_gnt;
    w_snoop_valid_nxt = 1'b0;
    w_snoop_op_nxt    = OP_NONE;
    w_snoop_addr_nxt  = r_snoop_addr;
    w_snoop_src_nxt   = r_snoop_src;
    w_l2_req_nxt      = r_l2_req;
    w_l2_addr_nxt     = r_l2_addr;
    w_resp_valid_nxt  = '0;
    w_resp_data_nxt   = r_resp_data;
    w_resp_shared_nxt = r_resp_shared;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_win_nxt         = w_pick;
          w_op_nxt          = bus.req_op[2*int'(w_pick) +: 2];
          w_addr_nxt        = bus.req_addr[ADDR_W*int'(w_pick) +: ADDR_W];
          w_gnt_nxt         = '0;
          w_gnt_nxt[w_pick] = 1'b1;
          w_snoop_valid_nxt = 1'b1;
          w_snoop_op_nxt    = bus.req_op[2*int'(w_pick) +: 2];
          w_snoop_addr_nxt  = bus.req_addr[ADDR_W*int'(w_pick) +: ADDR_W];
          w_snoop_src_nxt   = w_pick;
          w_state_nxt       = S_SNOOP;
        end
      end
      S_SNOOP: begin
        if (r_op == OP_BUSUPGR) begin
          w_resp_valid_nxt[r_win] = 1'b1;
          w_resp_data_nxt         = '0;
          w_resp_shared_nxt       = 1'b0;
          w_state_nxt             = S_RESP;
        end else if (w_peer_any) begin
          w_resp_valid_nxt[r_win] = 1'b1;
          w_resp_data_nxt         = bus.snoop_data[DATA_W*int'(w_peer) +: DATA_W];
          w_resp_shared_nxt       = 1'b1;
          w_state_nxt             = S_RESP;
        end else begin
          w_l2_req_nxt  = 1'b1;
          w_l2_addr_nxt = r_addr;
          w_state_nxt   = S_L2_WAIT;
        end
      end
      S_L2_WAIT: begin
        if (bus.l2_ready) begin
          w_l2_req_nxt            = 1'b0;
          w_resp_valid_nxt[r_win] = 1'b1;
          w_resp_data_nxt         = bus.l2_data;
          w_resp_shared_nxt       = 1'b0;
          w_state_nxt             = S_RESP;
        end
      end
      S_RESP: begin
        w_gnt_nxt         = '0;
        w_resp_data_nxt   = '0;
        w_resp_shared_nxt = 1'b0;
        w_rr_ptr_nxt      = (r_win == IDX_W'(NUM_CORES - 1)) ? '0 : r_win + 1'b1;
        w_state_nxt       = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_win         <= '0;
      r_op          <= OP_NONE;
      r_addr        <= '0;
      r_gnt         <= '0;
      r_snoop_valid <= 1'b0;
      r_snoop_op    <= OP_NONE;
      r_snoop_addr  <= '0;
      r_snoop_src   <= '0;
      r_l2_req      <= 1'b0;
      r_l2_addr     <= '0;
      r_resp_valid  <= '0;
      r_resp_data   <= '0;
      r_resp_shared <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_win         <= w_win_nxt;
      r_op          <= w_op_nxt;
      r_addr        <= w_addr_nxt;
      r_gnt         <= w_gnt_nxt;
      r_snoop_valid <= w_snoop_valid_nxt;
      r_snoop_op    <= w_snoop_op_nxt;
      r_snoop_addr  <= w_snoop_addr_nxt;
      r_snoop_src   <= w_snoop_src_nxt;
      r_l2_req      <= w_l2_req_nxt;
      r_l2_addr     <= w_l2_addr_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_data   <= w_resp_data_nxt;
      r_resp_shared <= w_resp_shared_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.snoop_valid = r_snoop_valid;
  assign bus.snoop_op    = r_snoop_op;
  assign bus.snoop_addr  = r_snoop_addr;
  assign bus.snoop_src   = r_snoop_src;
  assign bus.l2_req      = r_l2_req;
  assign bus.l2_addr     = r_l2_addr;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_data   = r_resp_data;
  assign bus.resp_shared = r_resp_shared;
  assign bus.busy        = r_busy;

  // OP_BUSRD documents the encoding; BusRd and BusRdX share the data path.
  logic w_unused_op;
  assign w_unused_op = (r_op == OP_BUSRD);
endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_bus_arbiter
// Brief    : Directed self-checking bench for the 4-core snoop bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_arbiter;
  localparam int NUM_CORES = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  snoop_bus_arbiter_if #(.NUM_CORES(NUM_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  snoop_bus_arbiter #(.NUM_CORES(NUM_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req        = '0;
    bus.req_op     = '1;
    bus.req_addr   = '0;
    bus.snoop_hit  = '0;
    bus.snoop_data = '0;
    bus.l2_ready   = 1'b0;
    bus.l2_data    = '0;
  endtask

  logic [3:0] exp_gnt [5];

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_gnt",         64'(bus.gnt),         64'h0);
    chk("rst_snoop_op",    64'(bus.snoop_op),    64'h3);
    chk("rst_snoop_valid", 64'(bus.snoop_valid), 64'h0);
    chk("rst_l2_req",      64'(bus.l2_req),      64'h0);
    chk("rst_resp_valid",  64'(bus.resp_valid),  64'h0);
    chk("rst_busy",        64'(bus.busy),        64'h0);
    reset = 1'b0;
    tick();
    chk("idle_gnt", 64'(bus.gnt), 64'h0);

    // Core1 BusRd 0x100, core2 supplies data
    bus.req[1] = 1'b1;
    bus.req_op[2 +: 2] = 2'b00;
    bus.req_addr[ADDR_W*1 +: ADDR_W] = 32'h100;
    tick();
    chk("t1_gnt",         64'(bus.gnt),         64'h2);
    chk("t1_snoop_valid", 64'(bus.snoop_valid), 64'h1);
    chk("t1_snoop_op",    64'(bus.snoop_op),    64'h0);
    chk("t1_snoop_addr",  64'(bus.snoop_addr),  64'h100);
    chk("t1_snoop_src",   64'(bus.snoop_src),   64'h1);
    chk("t1_busy",        64'(bus.busy),        64'h1);
    chk("t1_no_resp_yet", 64'(bus.resp_valid),  64'h0);
    bus.snoop_hit = 4'b0100;
    bus.snoop_data[DATA_W*2 +: DATA_W] = 32'hDEADBEEF;
    tick();
    chk("t1_resp_valid",  64'(bus.resp_valid),  64'h2);
    chk("t1_resp_data",   64'(bus.resp_data),   64'hDEADBEEF);
    chk("t1_shared",      64'(bus.resp_shared), 64'h1);
    chk("t1_no_l2",       64'(bus.l2_req),      64'h0);
    chk("t1_snoop_done",  64'(bus.snoop_valid), 64'h0);
    idle_inputs();
    tick();
    chk("t1_gnt_clear",   64'(bus.gnt),         64'h0);
    chk("t1_resp_clear",  64'(bus.resp_valid),  64'h0);
    chk("t1_idle",        64'(bus.busy),        64'h0);

    // Core2 BusUpgr with a core0 hit: no data movement, no L2
    bus.req[2] = 1'b1;
    bus.req_op[4 +: 2] = 2'b01;
    bus.req_addr[ADDR_W*2 +: ADDR_W] = 32'h300;
    tick();
    chk("t4_gnt",      64'(bus.gnt),      64'h4);
    chk("t4_snoop_op", 64'(bus.snoop_op), 64'h1);
    bus.snoop_hit = 4'b0001;
    bus.snoop_data[DATA_W*0 +: DATA_W] = 32'hCAFEF00D;
    tick();
    chk("t4_resp_valid", 64'(bus.resp_valid),  64'h4);
    chk("t4_resp_data",  64'(bus.resp_data),   64'h0);
    chk("t4_shared",     64'(bus.resp_shared), 64'h0);
    chk("t4_no_l2",      64'(bus.l2_req),      64'h0);
    idle_inputs();
    tick();

    // Core3 BusRd; own hit masked, cores 1 and 2 hit, core1 wins
    bus.req[3] = 1'b1;
    bus.req_op[6 +: 2] = 2'b00;
    bus.req_addr[ADDR_W*3 +: ADDR_W] = 32'h400;
    tick();
    chk("t5_gnt",       64'(bus.gnt),       64'h8);
    chk("t5_snoop_src", 64'(bus.snoop_src), 64'h3);
    bus.snoop_hit = 4'b1110;
    bus.snoop_data[DATA_W*1 +: DATA_W] = 32'h11111111;
    bus.snoop_data[DATA_W*2 +: DATA_W] = 32'h22222222;
    bus.snoop_data[DATA_W*3 +: DATA_W] = 32'h33333333;
    tick();
    chk("t5_resp_valid", 64'(bus.resp_valid),  64'h8);
    chk("t5_resp_data",  64'(bus.resp_data),   64'h11111111);
    chk("t5_shared",     64'(bus.resp_shared), 64'h1);
    idle_inputs();
    tick();

    // Core0 BusRdX, no hits, L2 ready three cycles after the request appears
    bus.req[0] = 1'b1;
    bus.req_op[0 +: 2] = 2'b10;
    bus.req_addr[ADDR_W*0 +: ADDR_W] = 32'h200;
    tick();
    chk("t2_gnt",      64'(bus.gnt),      64'h1);
    chk("t2_snoop_op", 64'(bus.snoop_op), 64'h2);
    tick();
    chk("t2_l2_req",    64'(bus.l2_req),     64'h1);
    chk("t2_l2_addr",   64'(bus.l2_addr),    64'h200);
    chk("t2_no_resp",   64'(bus.resp_valid), 64'h0);
    tick();
    chk("t2_l2_hold",   64'(bus.l2_req),     64'h1);
    tick();
    chk("t2_l2_hold2",  64'(bus.l2_req),     64'h1);
    bus.l2_ready = 1'b1;
    bus.l2_data  = 32'h12345678;
    tick();
    chk("t2_resp_valid", 64'(bus.resp_valid),  64'h1);
    chk("t2_resp_data",  64'(bus.resp_data),   64'h12345678);
    chk("t2_shared",     64'(bus.resp_shared), 64'h0);
    chk("t2_l2_drop",    64'(bus.l2_req),      64'h0);
    idle_inputs();
    tick();

    // Core1 goes to L2, reset lands during L2_WAIT
    bus.req[1] = 1'b1;
    bus.req_op[2 +: 2] = 2'b00;
    bus.req_addr[ADDR_W*1 +: ADDR_W] = 32'h500;
    tick();
    chk("t6_gnt", 64'(bus.gnt), 64'h2);
    tick();
    chk("t6_l2_req", 64'(bus.l2_req), 64'h1);
    reset = 1'b1;
    bus.l2_ready = 1'b1;
    bus.l2_data  = 32'h55555555;
    tick();
    chk("t6_l2_abort",   64'(bus.l2_req),     64'h0);
    chk("t6_gnt_abort",  64'(bus.gnt),        64'h0);
    chk("t6_no_resp",    64'(bus.resp_valid), 64'h0);
    reset = 1'b0;
    idle_inputs();
    tick();
    chk("t6_no_resp2",   64'(bus.resp_valid), 64'h0);

    // All cores request continuously; rr_ptr restarted at 0 by the reset
    exp_gnt[0] = 4'b0001;
    exp_gnt[1] = 4'b0010;
    exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000;
    exp_gnt[4] = 4'b0001;
    bus.req    = 4'b1111;
    bus.req_op = 8'b01_01_01_01;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("t3_gnt%0d", t), 64'(bus.gnt), 64'(exp_gnt[t]));
      tick();
      chk($sformatf("t3_resp%0d", t), 64'(bus.resp_valid), 64'(exp_gnt[t]));
      tick();
      chk($sformatf("t3_idle%0d", t), 64'(bus.gnt), 64'h0);
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
